// File: rtl/addsub_pkg.sv
// Shared definitions for the 4-bit adder/subtractor path: FSM encoding and default width.
package addsub_pkg;

  localparam int WIDTH_DEF = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/full_adder_cell.sv
// Single-bit gate-level full adder; carry is the majority of the three inputs.
module full_adder_cell (
  input  logic x,
  input  logic y,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = x ^ y ^ cin;
  assign cout = (x & y) | (x & cin) | (y & cin);

endmodule

// File: rtl/addsub4_serial.sv
// Bit-serial adder/subtractor: one sum bit per clock through a shared full-adder cell,
// with valid/ready handshakes on the operand and result sides.
//
//   state | meaning
//   IDLE  | ready for an operand pair
//   CALC  | resolving one bit per cycle, LSB first
//   DONE  | result presented, waiting for out_ready
module addsub4_serial
  import addsub_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sr_q, a_sr_d;
  logic [WIDTH-1:0] b_sr_q, b_sr_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             carry_q, carry_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  logic fa_s, fa_cout;

  full_adder_cell u_fa (
    .x    (a_sr_q[0]),
    .y    (b_sr_q[0]),
    .cin  (carry_q),
    .s    (fa_s),
    .cout (fa_cout)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      a_sr_q  <= '0;
      b_sr_q  <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_sr_q  <= a_sr_d;
      b_sr_q  <= b_sr_d;
      res_q   <= res_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    a_sr_d  = a_sr_q;
    b_sr_d  = b_sr_q;
    res_d   = res_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;

    case (state_q)
      ST_IDLE: begin
        if (in_valid && in_ready) begin
          a_sr_d  = a;
          b_sr_d  = b ^ {WIDTH{sub}};
          carry_d = sub;
          cnt_d   = '0;
          state_d = ST_CALC;
        end
      end
      ST_CALC: begin
        a_sr_d  = a_sr_q >> 1;
        b_sr_d  = b_sr_q >> 1;
        res_d   = {fa_s, res_q[WIDTH-1:1]};
        carry_d = fa_cout;
        if (cnt_q == LAST) begin
          // carry_q here is the carry into the MSB, needed for signed overflow
          sum_d   = {fa_s, res_q[WIDTH-1:1]};
          cout_d  = fa_cout;
          ovf_d   = carry_q ^ fa_cout;
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign in_ready  = (state_q == ST_IDLE) && !rst;
  assign out_valid = (state_q == ST_DONE);
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_addsub4_serial.sv
// Directed bench for addsub4_serial: hand-computed vectors, backpressure, reset abort, random stream.
module tb_addsub4_serial;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  addsub4_serial #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Reference: returns {cout, ovf, sum}; overflow judged from operand and result signs.
  function automatic logic [W+1:0] model(input logic [W-1:0] x, input logic [W-1:0] y, input logic s);
    logic [W:0]   full;
    logic [W-1:0] r;
    logic         v;
    full = s ? ({1'b0, x} + {1'b0, ~y} + (W+1)'(1)) : ({1'b0, x} + {1'b0, y});
    r = full[W-1:0];
    if (s) v = (x[W-1] != y[W-1]) && (r[W-1] != x[W-1]);
    else   v = (x[W-1] == y[W-1]) && (r[W-1] != x[W-1]);
    return {full[W], v, r};
  endfunction

  task automatic send(input string tag, input logic [W-1:0] ia, input logic [W-1:0] ib, input logic is);
    int n = 0;
    while (!in_ready && n < 20) begin tick; n++; end
    check({tag, "_ready"}, {31'd0, in_ready}, 32'd1);
    a = ia; b = ib; sub = is; in_valid = 1'b1;
    tick;
    in_valid = 1'b0;
    check({tag, "_accepted"}, {31'd0, in_ready}, 32'd0);
  endtask

  task automatic wait_out(input string tag);
    int n = 0;
    while (!out_valid && n < 20) begin tick; n++; end
    check({tag, "_latency"}, n, W);
  endtask

  task automatic run_op(input string tag, input logic [W-1:0] ia, input logic [W-1:0] ib,
                        input logic is, input logic [W-1:0] es, input logic ec, input logic eo);
    send(tag, ia, ib, is);
    wait_out(tag);
    check({tag, "_sum"}, {28'd0, sum}, {28'd0, es});
    check({tag, "_cout"}, {31'd0, cout}, {31'd0, ec});
    check({tag, "_ovf"}, {31'd0, ovf}, {31'd0, eo});
    out_ready = 1'b1;
    tick;
    out_ready = 1'b0;
    check({tag, "_valid_drop"}, {31'd0, out_valid}, 32'd0);
  endtask

  initial begin
    logic [W-1:0] hold_sum;
    logic         hold_cout, hold_ovf;
    logic         seen;
    logic [W+1:0] exp;
    int           last_acc, n;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; sub = 1'b0;
    #1;
    check("rst_in_ready", {31'd0, in_ready}, 32'd0);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_sum", {28'd0, sum}, 32'd0);
    check("rst_cout_ovf", {30'd0, cout, ovf}, 32'd0);
    tick; tick;
    rst = 1'b0;
    tick;
    check("post_rst_ready", {31'd0, in_ready}, 32'd1);

    run_op("add_5_3",   4'b0101, 4'b0011, 1'b0, 4'b1000, 1'b0, 1'b1);
    run_op("sub_7_2",   4'b0111, 4'b0010, 1'b1, 4'b0101, 1'b1, 1'b0);
    run_op("sub_2_7",   4'b0010, 4'b0111, 1'b1, 4'b1011, 1'b0, 1'b0);
    run_op("add_f_1",   4'b1111, 4'b0001, 1'b0, 4'b0000, 1'b1, 1'b0);
    run_op("add_8_f",   4'b1000, 4'b1111, 1'b0, 4'b0111, 1'b1, 1'b1);

    // Backpressure: result held in DONE while a stray in_valid pulse is ignored
    send("bp", 4'b0011, 4'b0100, 1'b0);
    wait_out("bp");
    hold_sum = sum; hold_cout = cout; hold_ovf = ovf;
    check("bp_sum", {28'd0, sum}, 32'd7);
    for (int i = 0; i < 3; i++) begin
      a = 4'b1111; b = 4'b1111; sub = 1'b1;
      in_valid = (i == 1);
      tick;
      check("bp_valid_hold", {31'd0, out_valid}, 32'd1);
      check("bp_ready_low", {31'd0, in_ready}, 32'd0);
      check("bp_sum_hold", {28'd0, sum}, {28'd0, hold_sum});
      check("bp_flags_hold", {30'd0, cout, ovf}, {30'd0, hold_cout, hold_ovf});
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick;
    out_ready = 1'b0;
    check("bp_idle_ready", {31'd0, in_ready}, 32'd1);
    check("bp_idle_valid", {31'd0, out_valid}, 32'd0);
    check("bp_sum_after", {28'd0, sum}, 32'd7);
    tick;
    check("bp_no_stray_accept", {31'd0, in_ready}, 32'd1);
    run_op("bp_next", 4'b0100, 4'b0001, 1'b1, 4'b0011, 1'b1, 1'b0);

    // out_ready and in_valid together in DONE: accept only on the following IDLE cycle
    send("ovl", 4'b0001, 4'b0001, 1'b0);
    wait_out("ovl");
    out_ready = 1'b1; in_valid = 1'b1; a = 4'b0010; b = 4'b0010; sub = 1'b0;
    tick;
    out_ready = 1'b0;
    check("ovl_idle_ready", {31'd0, in_ready}, 32'd1);
    check("ovl_sum", {28'd0, sum}, 32'd2);
    tick;
    in_valid = 1'b0;
    check("ovl_accept_next", {31'd0, in_ready}, 32'd0);
    wait_out("ovl2");
    check("ovl2_sum", {28'd0, sum}, 32'd4);
    out_ready = 1'b1;
    tick;
    out_ready = 1'b0;

    // Reset two cycles into a computation discards it
    send("rmid", 4'b0011, 4'b0100, 1'b0);
    tick;
    rst = 1'b1;
    #1;
    check("rmid_valid", {31'd0, out_valid}, 32'd0);
    check("rmid_sum", {28'd0, sum}, 32'd0);
    check("rmid_ready", {31'd0, in_ready}, 32'd0);
    seen = 1'b0;
    for (int i = 0; i < 3; i++) begin tick; seen |= out_valid; end
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin tick; seen |= out_valid; end
    check("rmid_never_valid", {31'd0, seen}, 32'd0);
    check("rmid_sum_clear", {28'd0, sum}, 32'd0);
    run_op("add_6_1", 4'b0110, 4'b0001, 1'b0, 4'b0111, 1'b0, 1'b0);

    // Back-to-back random stream with out_ready held high
    out_ready = 1'b1;
    last_acc = -1;
    for (int k = 0; k < 16; k++) begin
      a = W'($urandom_range(0, 15));
      b = W'($urandom_range(0, 15));
      sub = 1'($urandom_range(0, 1));
      exp = model(a, b, sub);
      in_valid = 1'b1;
      n = 0;
      while (!in_ready && n < 20) begin tick; n++; end
      check("rs_ready", {31'd0, in_ready}, 32'd1);
      tick;
      if (last_acc >= 0) check("rs_spacing", cyc - last_acc, W + 2);
      last_acc = cyc;
      wait_out("rs");
      check("rs_result", {26'd0, cout, ovf, sum}, {26'd0, exp});
    end
    in_valid = 1'b0;
    tick;
    out_ready = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
